ps2_kbd_decoder: RTL and testbench
==================================

// Module: ps2_kbd_decoder
// PURPOSE
//  - Upstream keyboard front end: receives raw PS/2 frames, tracks make/break/shift
//    state, and emits one ASCII byte per key press.
//  - Output pair ascii/ascii_ready feeds the custom text entry stage (char array
//    builder), which samples ascii on every cycle where ascii_ready is high.
// PARAMETERS
//  - TIMEOUT_CYC  27000  max clk cycles between PS/2 falling edges mid-frame (1 ms @ 27 MHz)
//  - FILTER_LEN   4      consecutive equal samples needed to accept a new PS/2 clock level
// PORTS
//  - clock_27mhz     in   1  system clock
//  - reset_n         in   1  asynchronous, active-low reset
//  - keyboard_clock  in   1  PS/2 clock, asynchronous to clock_27mhz
//  - keyboard_data   in   1  PS/2 data, asynchronous to clock_27mhz
//  - ascii           out  8  last decoded character; held until the next one
//  - ascii_ready     out  1  one-cycle strobe, ascii valid
//  - scan_code       out  8  last correctly framed byte (debug)
//  - frame_err       out  1  one-cycle strobe on parity, stop-bit or timeout error
// BEHAVIOUR
//  - Reset (reset_n=0, async): all outputs 0; shift/break/ext flags 0; receiver in IDLE.
//  - Input conditioning: 2-FF synchroniser on both lines. Filtered clock changes level
//    only after FILTER_LEN equal synchronised samples. Falling edge = filtered 1->0.
//  - Receiver FSM, one data sample per falling edge:
//      IDLE  data=0 -> RECV, bit_cnt=0; data=1 -> stay IDLE, no error.
//      RECV  shift in 8 bits LSB first, then the parity bit.
//            Odd parity over data+parity must be 1.
//      STOP  stop bit must be 1.
//            OK -> byte_valid next cycle; parity or stop bad -> frame_err pulse, byte dropped.
//            Always returns to IDLE.
//  - Timeout: in RECV/STOP, TIMEOUT_CYC cycles with no falling edge -> frame_err pulse,
//    partial byte dropped, IDLE. The timeout counter clears on every falling edge.
//  - Decoder, runs on byte_valid:
//      0xE0 -> ext=1.  0xF0 -> brk=1.  Neither produces output.
//      Any other byte with brk=1: release. Clear brk and ext; a shift release
//      (0x12/0x59) clears shift; no output.
//      Other byte with ext=1: clear ext; no output.
//      Make of 0x12/0x59 -> shift=1; no output.
//      Make of a mapped code -> ascii/ascii_ready. Unmapped code -> silently ignored.
//  - Map: letters 0x1C A, 0x32 B, 0x21 C, 0x23 D, 0x24 E, 0x2B F, 0x34 G, 0x33 H, 0x43 I,
//    0x3B J, 0x42 K, 0x4B L, 0x3A M, 0x31 N, 0x44 O, 0x4D P, 0x15 Q, 0x2D R, 0x1B S,
//    0x2C T, 0x3C U, 0x2A V, 0x1D W, 0x22 X, 0x35 Y, 0x1A Z.
//    Digits 0x45..'0', 0x16 '1', 0x1E '2', 0x26 '3', 0x25 '4', 0x2E '5', 0x36 '6',
//    0x3D '7', 0x3E '8', 0x46 '9'.
//    Others: 0x29 space 0x20, 0x5A enter 0x0D, 0x66 backspace 0x08, 0x41 ',', 0x49 '.',
//    0x4E '-'. Digits and punctuation are unaffected by shift.
//  - Latency: stop-bit falling edge detected at cycle N -> scan_code update and
//    byte_valid at N+1 -> ascii/ascii_ready at N+2.
//  - Back-to-back frames need no gap beyond PS/2 timing; the receiver has no busy state
//    after STOP.
//  - Reset mid-frame: partial byte discarded, no strobe; shift state lost.
// CONFIGURATION
//  - KBD_SHIFT_EN defined: letters output lowercase 0x61..0x7A; uppercase 0x41..0x5A
//    while shift=1.
//  - KBD_SHIFT_EN undefined: shift flag and logic not built; 0x12/0x59 are treated as
//    unmapped make/break codes; letters always uppercase.
// TESTING
//  - Frame 0x1C, good parity -> ascii=0x41 (no macro) or 0x61 (macro), ascii_ready
//    high exactly 1 cycle at N+2.
//  - Frames F0,1C after 0x1C -> no further ascii_ready; next 0x1C yields one new strobe.
//  - Frame 0x1C, bad parity -> frame_err 1 cycle, no ascii_ready, scan_code unchanged.
//  - 5 bits then idle > TIMEOUT_CYC -> frame_err pulse; following good 0x29 -> ascii=0x20.
//  - Macro on: 12,1C,F0,12,1C -> 0x41 then 0x61. Also E0,75 -> no output.
//  - reset_n low mid-frame, then frame 0x5A -> only ascii=0x0D strobe, no frame_err.

Source files
------------

// File: rtl/ps2_kbd_decoder_if.sv
// Decoded-keyboard output bundle: character strobe, last scan byte and frame error strobe.
// master = decoder side (drives), slave = consumer side (text entry stage, debug taps).
interface ps2_kbd_decoder_if;
    logic [7:0] ascii;
    logic       ascii_ready;
    logic [7:0] scan_code;
    logic       frame_err;

    modport master (output ascii, ascii_ready, scan_code, frame_err);
    modport slave  (input  ascii, ascii_ready, scan_code, frame_err);
endinterface

// File: rtl/ps2_kbd_decoder.sv
// PS/2 keyboard front end: conditions the raw lines, frames bytes, tracks make/break state
// and emits one ASCII byte per key press. Optional feature macro: KBD_SHIFT_EN (shift/lowercase).
module ps2_kbd_decoder #(
    parameter int TIMEOUT_CYC = 27000,
    parameter int FILTER_LEN  = 4
) (
    input  logic                clock_27mhz,
    input  logic                reset_n,
    input  logic                keyboard_clock,
    input  logic                keyboard_data,
    ps2_kbd_decoder_if.master   kbd
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {S_IDLE, S_RECV, S_STOP} rx_state_t;

    logic [1:0]    kc_sync;
    logic [1:0]    kd_sync;
    logic [FW-1:0] flt_cnt;
    logic          kc_filt;
    logic          fall_p0;

    rx_state_t     state, state_n;
    logic [3:0]    bit_cnt, bit_cnt_n;
    logic [7:0]    shreg, shreg_n;
    logic          par_ok, par_ok_n;
    logic [TW-1:0] tmo_cnt, tmo_cnt_n;
    logic          tmo_hit;
    logic [7:0]    scan_code_p1, scan_code_n;
    logic          byte_vld_p1, byte_vld_n;
    logic          frame_err_p1, frame_err_n;

    logic          ext_flag;
    logic          brk_flag;
    logic          lower_case;
    logic [7:0]    ascii_p2;
    logic          ascii_vld_p2;
    logic [8:0]    map_hit;

    // Scan code to ASCII: {mapped, character}; letters folded to lowercase on request.
    function automatic logic [8:0] map_code(input logic [7:0] code, input logic lower);
        logic [7:0] a;
        logic       hit;
        logic       letter;
        a      = 8'h00;
        hit    = 1'b1;
        letter = 1'b1;
        case (code)
            8'h1C: a = 8'h41;  8'h32: a = 8'h42;  8'h21: a = 8'h43;  8'h23: a = 8'h44;
            8'h24: a = 8'h45;  8'h2B: a = 8'h46;  8'h34: a = 8'h47;  8'h33: a = 8'h48;
            8'h43: a = 8'h49;  8'h3B: a = 8'h4A;  8'h42: a = 8'h4B;  8'h4B: a = 8'h4C;
            8'h3A: a = 8'h4D;  8'h31: a = 8'h4E;  8'h44: a = 8'h4F;  8'h4D: a = 8'h50;
            8'h15: a = 8'h51;  8'h2D: a = 8'h52;  8'h1B: a = 8'h53;  8'h2C: a = 8'h54;
            8'h3C: a = 8'h55;  8'h2A: a = 8'h56;  8'h1D: a = 8'h57;  8'h22: a = 8'h58;
            8'h35: a = 8'h59;  8'h1A: a = 8'h5A;
            default: begin
                letter = 1'b0;
                case (code)
                    8'h45: a = 8'h30;  8'h16: a = 8'h31;  8'h1E: a = 8'h32;  8'h26: a = 8'h33;
                    8'h25: a = 8'h34;  8'h2E: a = 8'h35;  8'h36: a = 8'h36;  8'h3D: a = 8'h37;
                    8'h3E: a = 8'h38;  8'h46: a = 8'h39;
                    8'h29: a = 8'h20;  8'h5A: a = 8'h0D;  8'h66: a = 8'h08;
                    8'h41: a = 8'h2C;  8'h49: a = 8'h2E;  8'h4E: a = 8'h2D;
                    default: hit = 1'b0;
                endcase
            end
        endcase
        if (letter && lower) a = a | 8'h20;
        return {hit, a};
    endfunction

    // Stage p0: synchronise both lines, deglitch the PS/2 clock, flag its falling edge
    always_ff @(posedge clock_27mhz or negedge reset_n) begin
        if (!reset_n) begin
            kc_sync <= 2'b11;
            kd_sync <= 2'b11;
            flt_cnt <= '0;
            kc_filt <= 1'b1;
            fall_p0 <= 1'b0;
        end else begin
            kc_sync <= {kc_sync[0], keyboard_clock};
            kd_sync <= {kd_sync[0], keyboard_data};
            fall_p0 <= 1'b0;
            if (kc_sync[1] == kc_filt) begin
                flt_cnt <= '0;
            end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
                kc_filt <= kc_sync[1];
                flt_cnt <= '0;
                fall_p0 <= kc_filt;
            end else begin
                flt_cnt <= flt_cnt + 1'b1;
            end
        end
    end

    // Stage p1: frame receiver, scan code register and byte strobe
    always_ff @(posedge clock_27mhz or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            bit_cnt      <= '0;
            shreg        <= '0;
            par_ok       <= 1'b0;
            tmo_cnt      <= '0;
            scan_code_p1 <= '0;
            byte_vld_p1  <= 1'b0;
            frame_err_p1 <= 1'b0;
        end else begin
            state        <= state_n;
            bit_cnt      <= bit_cnt_n;
            shreg        <= shreg_n;
            par_ok       <= par_ok_n;
            tmo_cnt      <= tmo_cnt_n;
            scan_code_p1 <= scan_code_n;
            byte_vld_p1  <= byte_vld_n;
            frame_err_p1 <= frame_err_n;
        end
    end

    assign tmo_hit = (tmo_cnt == TW'(TIMEOUT_CYC - 1));

    always_comb begin
        state_n     = state;
        bit_cnt_n   = bit_cnt;
        shreg_n     = shreg;
        par_ok_n    = par_ok;
        tmo_cnt_n   = tmo_cnt;
        scan_code_n = scan_code_p1;
        byte_vld_n  = 1'b0;
        frame_err_n = 1'b0;
        case (state)
            S_IDLE: begin
                tmo_cnt_n = '0;
                if (fall_p0 && !kd_sync[1]) begin
                    state_n   = S_RECV;
                    bit_cnt_n = '0;
                end
            end
            S_RECV: begin
                if (fall_p0) begin
                    tmo_cnt_n = '0;
                    if (bit_cnt < 4'd8) begin
                        shreg_n   = {kd_sync[1], shreg[7:1]};
                        bit_cnt_n = bit_cnt + 4'd1;
                    end else begin
                        par_ok_n = ^{shreg, kd_sync[1]};
                        state_n  = S_STOP;
                    end
                end else if (tmo_hit) begin
                    frame_err_n = 1'b1;
                    tmo_cnt_n   = '0;
                    state_n     = S_IDLE;
                end else begin
                    tmo_cnt_n = tmo_cnt + 1'b1;
                end
            end
            S_STOP: begin
                if (fall_p0) begin
                    tmo_cnt_n = '0;
                    state_n   = S_IDLE;
                    if (kd_sync[1] && par_ok) begin
                        byte_vld_n  = 1'b1;
                        scan_code_n = shreg;
                    end else begin
                        frame_err_n = 1'b1;
                    end
                end else if (tmo_hit) begin
                    frame_err_n = 1'b1;
                    tmo_cnt_n   = '0;
                    state_n     = S_IDLE;
                end else begin
                    tmo_cnt_n = tmo_cnt + 1'b1;
                end
            end
            default: begin
                state_n   = S_IDLE;
                tmo_cnt_n = '0;
            end
        endcase
    end

`ifdef KBD_SHIFT_EN
    logic shift_flag;

    always_ff @(posedge clock_27mhz or negedge reset_n) begin
        if (!reset_n) begin
            shift_flag <= 1'b0;
        end else if (byte_vld_p1 && scan_code_p1 != 8'hE0 && scan_code_p1 != 8'hF0 &&
                     (scan_code_p1 == 8'h12 || scan_code_p1 == 8'h59)) begin
            if (brk_flag) shift_flag <= 1'b0;
            else if (!ext_flag) shift_flag <= 1'b1;
        end
    end

    assign lower_case = ~shift_flag;
`else
    assign lower_case = 1'b0;
`endif

    assign map_hit = map_code(scan_code_p1, lower_case);

    // Stage p2: make/break/extended tracking and character strobe
    always_ff @(posedge clock_27mhz or negedge reset_n) begin
        if (!reset_n) begin
            ext_flag     <= 1'b0;
            brk_flag     <= 1'b0;
            ascii_p2     <= '0;
            ascii_vld_p2 <= 1'b0;
        end else begin
            ascii_vld_p2 <= 1'b0;
            if (byte_vld_p1) begin
                if (scan_code_p1 == 8'hE0) begin
                    ext_flag <= 1'b1;
                end else if (scan_code_p1 == 8'hF0) begin
                    brk_flag <= 1'b1;
                end else if (brk_flag) begin
                    brk_flag <= 1'b0;
                    ext_flag <= 1'b0;
                end else if (ext_flag) begin
                    ext_flag <= 1'b0;
`ifdef KBD_SHIFT_EN
                end else if (scan_code_p1 == 8'h12 || scan_code_p1 == 8'h59) begin
                    ext_flag <= 1'b0;
`endif
                end else if (map_hit[8]) begin
                    ascii_p2     <= map_hit[7:0];
                    ascii_vld_p2 <= 1'b1;
                end
            end
        end
    end

    assign kbd.ascii       = ascii_p2;
    assign kbd.ascii_ready = ascii_vld_p2;
    assign kbd.scan_code   = scan_code_p1;
    assign kbd.frame_err   = frame_err_p1;

endmodule

// File: tb/tb_ps2_kbd_decoder.sv
// Directed bench for ps2_kbd_decoder: table of PS/2 frames with expected strobes,
// plus hand-written timeout and mid-frame reset sequences.
module tb_ps2_kbd_decoder;

    localparam int HALF   = 20;
    localparam int TMO    = 200;
    localparam int FLT    = 4;
    localparam int LAT    = 2 + FLT + 2;
`ifdef KBD_SHIFT_EN
    localparam logic [7:0] A_EXP = 8'h61;
`else
    localparam logic [7:0] A_EXP = 8'h41;
`endif

    typedef struct {
        logic [7:0] code;
        logic       bad_par;
        logic       bad_stop;
        int         exp_rdy;
        logic [7:0] exp_ascii;
        int         exp_err;
    } vec_t;

    logic clk;
    logic rst_n;
    logic kclk;
    logic kdat;

    ps2_kbd_decoder_if kbd ();

    ps2_kbd_decoder #(.TIMEOUT_CYC(TMO), .FILTER_LEN(FLT)) dut (
        .clock_27mhz    (clk),
        .reset_n        (rst_n),
        .keyboard_clock (kclk),
        .keyboard_data  (kdat),
        .kbd            (kbd.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         rdy_cnt  = 0;
    int         err_cnt  = 0;
    int         wide_cnt = 0;
    int         rdy_cyc  = 0;
    logic [7:0] last_ascii = 8'h00;
    logic       prev_rdy = 1'b0;
    logic       prev_err = 1'b0;

    always @(negedge clk) begin
        if (kbd.ascii_ready) begin
            rdy_cnt    = rdy_cnt + 1;
            rdy_cyc    = cyc;
            last_ascii = kbd.ascii;
        end
        if (kbd.frame_err) err_cnt = err_cnt + 1;
        if ((kbd.ascii_ready && prev_rdy) || (kbd.frame_err && prev_err)) wide_cnt = wide_cnt + 1;
        prev_rdy = kbd.ascii_ready;
        prev_err = kbd.frame_err;
    end

    int errors = 0;
    int checks = 0;
    int stop_cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            kdat = bits[i];
            repeat (HALF) @(negedge clk);
            kclk = 1'b0;
            if (i == 10) stop_cyc = cyc;
            repeat (HALF) @(negedge clk);
            kclk = 1'b1;
        end
        @(negedge clk);
        kdat = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
        logic par;
        par = (~^b) ^ bad_par;
        send_bits({~bad_stop, par, b, 1'b0}, 11);
        repeat (2 * HALF) @(negedge clk);
    endtask

    vec_t vecs[$];

    function automatic vec_t mk(input logic [7:0] c, input logic bp, input logic bs,
                                input int r, input logic [7:0] a, input int e);
        vec_t v;
        v.code = c; v.bad_par = bp; v.bad_stop = bs;
        v.exp_rdy = r; v.exp_ascii = a; v.exp_err = e;
        return v;
    endfunction

    initial begin
        logic [7:0] exp_scan;
        logic [7:0] exp_held;
        int r0, e0;

        vecs.push_back(mk(8'h1C, 0, 0, 1, A_EXP, 0));
        vecs.push_back(mk(8'hF0, 0, 0, 0, 8'h00, 0));
        vecs.push_back(mk(8'h1C, 0, 0, 0, 8'h00, 0));
        vecs.push_back(mk(8'h1C, 0, 0, 1, A_EXP, 0));
        vecs.push_back(mk(8'h29, 0, 0, 1, 8'h20, 0));
        vecs.push_back(mk(8'h1C, 1, 0, 0, 8'h00, 1));
        vecs.push_back(mk(8'h5A, 0, 1, 0, 8'h00, 1));
        vecs.push_back(mk(8'h45, 0, 0, 1, 8'h30, 0));
        vecs.push_back(mk(8'h16, 0, 0, 1, 8'h31, 0));
        vecs.push_back(mk(8'h4E, 0, 0, 1, 8'h2D, 0));
        vecs.push_back(mk(8'h49, 0, 0, 1, 8'h2E, 0));
        vecs.push_back(mk(8'h66, 0, 0, 1, 8'h08, 0));
        vecs.push_back(mk(8'h5A, 0, 0, 1, 8'h0D, 0));
        vecs.push_back(mk(8'hE0, 0, 0, 0, 8'h00, 0));
        vecs.push_back(mk(8'h75, 0, 0, 0, 8'h00, 0));
        vecs.push_back(mk(8'h75, 0, 0, 0, 8'h00, 0));
        vecs.push_back(mk(8'hE0, 0, 0, 0, 8'h00, 0));
        vecs.push_back(mk(8'h1C, 0, 0, 0, 8'h00, 0));
        vecs.push_back(mk(8'h1A, 0, 0, 1, A_EXP + 8'h19, 0));
        vecs.push_back(mk(8'h12, 0, 0, 0, 8'h00, 0));
        vecs.push_back(mk(8'h1C, 0, 0, 1, 8'h41, 0));
        vecs.push_back(mk(8'hF0, 0, 0, 0, 8'h00, 0));
        vecs.push_back(mk(8'h12, 0, 0, 0, 8'h00, 0));
        vecs.push_back(mk(8'h1C, 0, 0, 1, A_EXP, 0));

        rst_n = 1'b0;
        kclk  = 1'b1;
        kdat  = 1'b1;
        repeat (5) @(negedge clk);
        chk("reset_ascii", kbd.ascii, 0);
        chk("reset_ready", kbd.ascii_ready, 0);
        chk("reset_scan", kbd.scan_code, 0);
        chk("reset_err", kbd.frame_err, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        exp_scan = 8'h00;
        exp_held = 8'h00;
        for (int i = 0; i < vecs.size(); i++) begin
            r0 = rdy_cnt;
            e0 = err_cnt;
            send_frame(vecs[i].code, vecs[i].bad_par, vecs[i].bad_stop);
            if (!vecs[i].bad_par && !vecs[i].bad_stop) exp_scan = vecs[i].code;
            chk($sformatf("v%0d_ready_count", i), rdy_cnt - r0, vecs[i].exp_rdy);
            chk($sformatf("v%0d_err_count", i), err_cnt - e0, vecs[i].exp_err);
            chk($sformatf("v%0d_scan_code", i), kbd.scan_code, exp_scan);
            if (vecs[i].exp_rdy == 1) begin
                exp_held = vecs[i].exp_ascii;
                chk($sformatf("v%0d_ascii", i), last_ascii, vecs[i].exp_ascii);
                chk($sformatf("v%0d_latency", i), rdy_cyc - stop_cyc, LAT);
            end
            chk($sformatf("v%0d_ascii_held", i), kbd.ascii, exp_held);
        end

        // Timeout: start bit plus four data bits, then silence past the limit
        r0 = rdy_cnt;
        e0 = err_cnt;
        send_bits(11'b000_0000_1010, 5);
        repeat (TMO + 60) @(negedge clk);
        chk("tmo_err_count", err_cnt - e0, 1);
        chk("tmo_ready_count", rdy_cnt - r0, 0);
        send_frame(8'h29, 0, 0);
        chk("tmo_next_ready", rdy_cnt - r0, 1);
        chk("tmo_next_ascii", last_ascii, 8'h20);
        chk("tmo_next_err", err_cnt - e0, 1);

        // Reset in the middle of a frame
        send_bits(11'b000_0000_0100, 4);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst_ascii", kbd.ascii, 0);
        chk("midrst_scan", kbd.scan_code, 0);
        chk("midrst_ready", kbd.ascii_ready, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        r0 = rdy_cnt;
        e0 = err_cnt;
        send_frame(8'h5A, 0, 0);
        chk("midrst_ready_count", rdy_cnt - r0, 1);
        chk("midrst_enter", last_ascii, 8'h0D);
        chk("midrst_err_count", err_cnt - e0, 0);
        chk("midrst_scan_after", kbd.scan_code, 8'h5A);

        chk("strobe_width", wide_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule
